// File: rtl/gmsk_burst_sequencer.sv
// Burst sequencer for the GMSK I/Q modulator: sample-strobe divider plus a per-burst
// lead-tail / payload / trail-tail / guard symbol FSM. Optional macro: GMSK_BURST_DIFF_ENCODE_EN.
module gmsk_burst_sequencer #(
  parameter int CLOCKS_PER_SAMPLE = 24,
  parameter int TAIL_BITS         = 3,
  parameter int PAYLOAD_BITS      = 142,
  parameter int GUARD_SYMBOLS     = 8,
  parameter int CNT_BITS          = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic burst_start,
  output logic burst_busy,
  output logic burst_done,
  input  logic payload_bit,
  input  logic payload_valid,
  output logic payload_ready,
  output logic payload_underrun,
  output logic sample_strobe,
  output logic current_symbol,
  input  logic next_symbol_strobe,
  output logic tx_enable
);

  localparam int DIV_BITS = (CLOCKS_PER_SAMPLE > 2) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
  localparam logic [DIV_BITS-1:0] DIV_LAST   = DIV_BITS'(CLOCKS_PER_SAMPLE - 1);
  localparam logic [CNT_BITS-1:0] TAIL_LAST  = CNT_BITS'(TAIL_BITS - 1);
  localparam logic [CNT_BITS-1:0] PAY_LAST   = CNT_BITS'(PAYLOAD_BITS - 1);
  localparam logic [CNT_BITS-1:0] GUARD_LAST = CNT_BITS'(GUARD_SYMBOLS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEAD    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_TRAIL   = 3'd3,
    S_GUARD   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic                strobe_q, strobe_d;
  logic                sym_q, sym_d;
  logic                pending_q, pending_d;
  logic                underrun_q, underrun_d;
  logic                tx_en_q, tx_en_d;
  logic                done_q, done_d;
  logic                advance_s;
  logic                fetch_s;
  logic                raw_s;
`ifdef GMSK_BURST_DIFF_ENCODE_EN
  logic                prev_q, prev_d;
`endif

  assign advance_s = strobe_q & next_symbol_strobe;

  // Next-state logic: divider, burst FSM, payload fetch and symbol encoding
  always_comb begin
    div_d      = (div_q == DIV_LAST) ? {DIV_BITS{1'b0}} : div_q + DIV_BITS'(1);
    strobe_d   = (div_d == DIV_LAST);
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    fetch_s    = 1'b0;
    raw_s      = 1'b0;
    sym_d      = sym_q;
`ifdef GMSK_BURST_DIFF_ENCODE_EN
    prev_d     = prev_q;
`endif

    if (burst_start && (state_q == S_IDLE) && !pending_q) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    if (advance_s) begin
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            state_d    = S_LEAD;
            cnt_d      = {CNT_BITS{1'b0}};
            pending_d  = 1'b0;
            underrun_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LEAD: begin
          if (cnt_q == TAIL_LAST) begin
            state_d = S_PAYLOAD;
            cnt_d   = {CNT_BITS{1'b0}};
            fetch_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        S_PAYLOAD: begin
          if (cnt_q == PAY_LAST) begin
            state_d = S_TRAIL;
            cnt_d   = {CNT_BITS{1'b0}};
          end else begin
            cnt_d   = cnt_q + CNT_BITS'(1);
            fetch_s = 1'b1;
          end
        end
        S_TRAIL: begin
          if (cnt_q == TAIL_LAST) begin
            state_d = S_GUARD;
            cnt_d   = {CNT_BITS{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        S_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_BITS{1'b0}};
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CNT_BITS{1'b0}};
        end
      endcase

      // A missing payload bit becomes a zero symbol; the burst length never changes
      if (fetch_s) begin
        if (payload_valid) begin
          raw_s = payload_bit;
        end else begin
          raw_s      = 1'b0;
          underrun_d = 1'b1;
        end
      end else begin
        raw_s = 1'b0;
      end

`ifdef GMSK_BURST_DIFF_ENCODE_EN
      if (state_d == S_IDLE) begin
        sym_d = 1'b0;
      end else if (state_q == S_IDLE) begin
        sym_d  = raw_s ^ 1'b1;
        prev_d = raw_s;
      end else begin
        sym_d  = raw_s ^ prev_q;
        prev_d = raw_s;
      end
`else
      sym_d = raw_s;
`endif
    end else begin
      sym_d = sym_q;
    end

    tx_en_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_BITS{1'b0}};
      div_q      <= {DIV_BITS{1'b0}};
      strobe_q   <= 1'b0;
      sym_q      <= 1'b0;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
      tx_en_q    <= 1'b0;
      done_q     <= 1'b0;
`ifdef GMSK_BURST_DIFF_ENCODE_EN
      prev_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      strobe_q   <= strobe_d;
      sym_q      <= sym_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
      tx_en_q    <= tx_en_d;
      done_q     <= done_d;
`ifdef GMSK_BURST_DIFF_ENCODE_EN
      prev_q     <= prev_d;
`endif
    end
  end

  assign sample_strobe    = strobe_q;
  assign current_symbol   = sym_q;
  assign tx_enable        = tx_en_q;
  assign burst_done       = done_q;
  assign payload_underrun = underrun_q;
  assign payload_ready    = fetch_s;
  assign burst_busy       = pending_q | (state_q != S_IDLE);

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Self-checking bench for gmsk_burst_sequencer: stub modulator, payload source and
// a table of burst vectors, plus reset, back-to-back and mid-burst-reset sequences.
module tb_gmsk_burst_sequencer;

  localparam int SYM_CLKS = 31 * 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic burst_start = 1'b0;
  logic payload_bit, payload_valid, next_symbol_strobe;
  logic burst_busy, burst_done, payload_ready, payload_underrun;
  logic sample_strobe, current_symbol, tx_enable;

  gmsk_burst_sequencer #(
    .CLOCKS_PER_SAMPLE(4), .TAIL_BITS(3), .PAYLOAD_BITS(8), .GUARD_SYMBOLS(2), .CNT_BITS(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .burst_start(burst_start),
    .burst_busy(burst_busy), .burst_done(burst_done),
    .payload_bit(payload_bit), .payload_valid(payload_valid), .payload_ready(payload_ready),
    .payload_underrun(payload_underrun), .sample_strobe(sample_strobe),
    .current_symbol(current_symbol), .next_symbol_strobe(next_symbol_strobe),
    .tx_enable(tx_enable)
  );

  always #5 clock = ~clock;

  // Stub modulator: one symbol every 31 sample strobes
  int scnt;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) scnt <= 0;
    else if (sample_strobe) scnt <= (scnt == 30) ? 0 : scnt + 1;
  end
  assign next_symbol_strobe = sample_strobe && (scnt == 30);

  // Payload source indexed by the number of payload slots consumed in the burst
  int slot_cnt = 0;
  int slot_base = 0;
  int slot_rel;
  int drop_slot = -1;
  logic [7:0] cur_word = 8'h00;
  always @(posedge clock) if (payload_ready) slot_cnt <= slot_cnt + 1;
  always_comb begin
    slot_rel      = slot_cnt - slot_base;
    payload_valid = (slot_rel != drop_slot);
    payload_bit   = (slot_rel >= 0 && slot_rel < 8) ? cur_word[3'(7 - slot_rel)] : 1'b0;
  end

  // Monitor, sampled mid-cycle
  int done_cnt = 0, ready_cnt = 0, tx_adv_cnt = 0, idle_adv_cnt = 0;
  logic [15:0] cap = 16'h0000;
  always @(negedge clock) begin
    if (burst_done) done_cnt <= done_cnt + 1;
    if (payload_ready) ready_cnt <= ready_cnt + 1;
    if (sample_strobe && next_symbol_strobe) begin
      if (tx_enable) begin
        tx_adv_cnt <= tx_adv_cnt + 1;
        cap        <= {cap[14:0], current_symbol};
      end else begin
        idle_adv_cnt <= idle_adv_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [7:0]  word;
    int          drop;
    logic [15:0] exp_sym;
    logic        exp_under;
  } vec_t;
  vec_t vecs[4];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_tx(input logic level, input int limit);
    int n = 0;
    while (tx_enable !== level && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("tx_enable_wait_timeout", (n >= limit) ? 1 : 0, 0);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (burst_done !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("burst_done_wait_timeout", (n >= limit) ? 1 : 0, 0);
  endtask

  task automatic run_burst(input int vi, input bit prestarted, input bit chain);
    int d0, r0, a0, i0;
    cur_word  = vecs[vi].word;
    drop_slot = vecs[vi].drop;
    slot_base = slot_cnt;
    d0 = done_cnt; r0 = ready_cnt; a0 = tx_adv_cnt; i0 = idle_adv_cnt;
    if (!prestarted) begin
      @(negedge clock) burst_start = 1'b1;
      @(negedge clock) burst_start = 1'b0;
    end
    check("busy_after_start", burst_busy, 1);
    wait_tx(1'b1, 2 * SYM_CLKS + 10);
    check("underrun_clear_at_start", payload_underrun, 0);
    if (prestarted) check("one_idle_symbol_between", idle_adv_cnt - i0, 1);
    repeat (300) @(negedge clock);
    burst_start = 1'b1;
    @(negedge clock) burst_start = 1'b0;
    wait_done(20 * SYM_CLKS);
    check("tx_off_with_done", tx_enable, 0);
    check("symbols", cap, vecs[vi].exp_sym);
    check("ready_pulses", ready_cnt - r0, 8);
    check("burst_length", tx_adv_cnt - a0, 16);
    check("underrun_flag", payload_underrun, vecs[vi].exp_under);
    if (chain) burst_start = 1'b1;
    @(negedge clock) burst_start = 1'b0;
    check("done_single_pulse", done_cnt - d0, 1);
    if (!chain) begin
      repeat (SYM_CLKS + 20) @(negedge clock);
      check("midburst_start_ignored", tx_enable | burst_busy, 0);
      check("underrun_held", payload_underrun, vecs[vi].exp_under);
    end
  endtask

  initial begin
    int d0, r0, n;
`ifdef GMSK_BURST_DIFF_ENCODE_EN
    vecs[0] = '{8'b10110010, -1, 16'h9D60, 1'b0};
    vecs[1] = '{8'b10110010,  3, 16'h9E60, 1'b1};
    vecs[2] = '{8'b11111111, -1, 16'h9010, 1'b0};
    vecs[3] = '{8'b00000001,  7, 16'h8000, 1'b1};
`else
    vecs[0] = '{8'b10110010, -1, 16'h1640, 1'b0};
    vecs[1] = '{8'b10110010,  3, 16'h1440, 1'b1};
    vecs[2] = '{8'b11111111, -1, 16'h1FE0, 1'b0};
    vecs[3] = '{8'b00000001,  7, 16'h0000, 1'b1};
`endif

    // Reset and divider phase
    reset_n = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_outputs", {burst_busy, burst_done, payload_ready, payload_underrun,
                          sample_strobe, current_symbol, tx_enable}, 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      check($sformatf("strobe_cycle_%0d", k), sample_strobe, (k % 4 == 3) ? 1 : 0);
    end
    check("post_rst_outputs", {burst_busy, burst_done, tx_enable, current_symbol}, 0);

    for (int v = 0; v < 4; v++) run_burst(v, 1'b0, 1'b0);

    // Back-to-back: request in the burst_done cycle
    run_burst(2, 1'b0, 1'b1);
    run_burst(0, 1'b1, 1'b0);

    // Reset during PAYLOAD
    cur_word = vecs[0].word; drop_slot = -1; slot_base = slot_cnt;
    r0 = ready_cnt;
    @(negedge clock) burst_start = 1'b1;
    @(negedge clock) burst_start = 1'b0;
    wait_tx(1'b1, 2 * SYM_CLKS + 10);
    n = 0;
    while ((ready_cnt - r0) < 2 && n < 10 * SYM_CLKS) begin
      @(negedge clock);
      n++;
    end
    check("reach_payload_timeout", (n >= 10 * SYM_CLKS) ? 1 : 0, 0);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_mid_tx_enable", tx_enable, 0);
    check("rst_mid_busy", burst_busy, 0);
    check("rst_mid_symbol", current_symbol, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2 * SYM_CLKS) @(negedge clock);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_idle", tx_enable | burst_busy, 0);
    run_burst(0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
